// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX launch sequencer states.
// No logic; imported by the FIFO, its interface and the launch sequencer.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } tx_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-producer write port plus the level start/busy handshake towards uart_tx.
// master = producer/transmitter side, slave = uart_tx_fifo.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              flush;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;

  modport master (
    output wr_data, wr_valid, flush, tx_busy,
    input  tx_start, tx_data, count, full, empty, overflow
  );

  modport slave (
    input  wr_data, wr_valid, flush, tx_busy,
    output tx_start, tx_data, count, full, empty, overflow
  );

endinterface

// File: rtl/byte_fifo.sv
// DEPTH-entry byte FIFO in registers; count/full/empty valid the cycle after a push/pop.
// Writes while full are ignored; flush clears pointers and count and wins over a write.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push;
  logic              pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // full is the pre-pop state, so a write at full is lost even if a pop frees a slot
  assign push = wr_valid_i && !full_o && !flush_i;
  assign pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Queues bytes and launches them into uart_tx one at a time; tx_start rises 2 cycles after a write when idle.
// Drops writes while full (overflow pulse next cycle); waits on tx_busy between bytes.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  uart_tx_fifo_if.slave bus
);

  tx_fifo_state_t    state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic              pop;
  logic              launch;
  logic [DATA_W-1:0] head;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_byte_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (bus.flush),
    .wr_valid_i (bus.wr_valid),
    .wr_data_i  (bus.wr_data),
    .pop_i      (pop),
    .rd_data_o  (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  // flush blocks new launches but never aborts a byte already handed over
  assign launch = (state_q == IDLE) && !empty && !bus.tx_busy && !bus.flush;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch)       state_d = START;
      START:   if (bus.tx_busy)  state_d = SEND;
      SEND:    if (!bus.tx_busy) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = head;
        end
      end
      START:   if (bus.tx_busy) tx_start_d = 1'b0;
      default: tx_start_d = 1'b0;
    endcase
  end

  assign overflow_d = bus.wr_valid && full && !bus.flush;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.overflow = overflow_q;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations and a small uart_tx busy responder.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int DLY   = 5;
  localparam int LEN   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // uart_tx stand-in: busy rises DLY cycles after seeing tx_start, stays high LEN+1 cycles
  logic auto_busy  = 1'b0;
  logic force_busy = 1'b0;
  logic auto_b;
  int   cnt;
  int   nxt;
  assign bus.tx_busy = auto_busy ? auto_b : force_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !auto_busy) begin
      cnt    <= 0;
      auto_b <= 1'b0;
    end else begin
      nxt = cnt;
      if (cnt == 0) begin
        if (bus.tx_start) nxt = 1;
      end else if (cnt >= DLY + LEN) begin
        nxt = 0;
      end else begin
        nxt = cnt + 1;
      end
      cnt    <= nxt;
      auto_b <= (nxt >= DLY);
    end
  end

  // Reference model: a byte queue plus "request outstanding" / "transfer in progress" flags
  logic [7:0] q[$];
  logic       m_start  = 1'b0;
  logic       m_active = 1'b0;
  logic       m_ovf    = 1'b0;
  logic [7:0] m_data   = 8'h00;

  always @(posedge clk or negedge rst_n) begin : model
    bit launch;
    bit was_full;
    if (!rst_n) begin
      q.delete();
      m_start  = 1'b0;
      m_active = 1'b0;
      m_ovf    = 1'b0;
      m_data   = 8'h00;
    end else begin
      was_full = (q.size() == DEPTH);
      launch   = !m_active && (q.size() != 0) && !bus.tx_busy && !bus.flush;
      m_ovf    = bus.wr_valid && was_full && !bus.flush;
      if (bus.flush) begin
        q.delete();
      end else begin
        if (launch) m_data = q.pop_front();
        if (bus.wr_valid && !was_full) q.push_back(bus.wr_data);
      end
      if (launch) begin
        m_active = 1'b1;
        m_start  = 1'b1;
      end else if (m_start && bus.tx_busy) begin
        m_start = 1'b0;
      end else if (m_active && !m_start && !bus.tx_busy) begin
        m_active = 1'b0;
      end
    end
  end

  logic [7:0] emitted[$];
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_count",    32'(bus.count),  32'(q.size()));
      check("cyc_full",     32'(bus.full),   32'(q.size() == DEPTH));
      check("cyc_empty",    32'(bus.empty),  32'(q.size() == 0));
      check("cyc_tx_start", 32'(bus.tx_start), 32'(m_start));
      check("cyc_tx_data",  32'(bus.tx_data),  32'(m_data));
      check("cyc_overflow", 32'(bus.overflow), 32'(m_ovf));
      if (bus.tx_start && !prev_start) emitted.push_back(bus.tx_data);
      prev_start = bus.tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic write_byte(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.count == 0 && !bus.tx_start && !bus.tx_busy && cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    check(name, 32'(ok), 32'd1);
  endtask

  int         base;
  int         busy_at;
  int         fall_at;
  logic [7:0] t4_exp [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};

  initial begin
    rst_n        = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_empty",    32'(bus.empty),    32'd1);
    check("rst_full",     32'(bus.full),     32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data",  32'(bus.tx_data),  32'h00);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    bus.wr_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    check("rel_empty",    32'(bus.empty),    32'd1);
    check("rel_count",    32'(bus.count),    32'd0);
    check("rel_tx_start", 32'(bus.tx_start), 32'd0);

    // Single byte: launch two cycles after the strobe, start drops right after busy
    auto_busy = 1'b1;
    write_byte(8'h41);
    check("t2_count1",    32'(bus.count),    32'd1);
    check("t2_no_start",  32'(bus.tx_start), 32'd0);
    @(negedge clk);
    check("t2_start",     32'(bus.tx_start), 32'd1);
    check("t2_data",      32'(bus.tx_data),  32'h41);
    check("t2_count0",    32'(bus.count),    32'd0);
    busy_at = -1;
    fall_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.tx_busy && busy_at < 0) busy_at = k;
      if (!bus.tx_start) begin
        fall_at = k;
        break;
      end
    end
    check("t2_busy_delay", 32'(busy_at), 32'd5);
    check("t2_fall_gap",   32'(fall_at - busy_at), 32'd1);
    wait_idle("t2_idle");

    // Fill to DEPTH with transmitter busy, then one extra byte that must be dropped
    base       = emitted.size();
    auto_busy  = 1'b0;
    force_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = (i < 16) ? 8'(i) : 8'hAA;
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    check("t3_full",     32'(bus.full),     32'd1);
    check("t3_count",    32'(bus.count),    32'd16);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    @(negedge clk);
    check("t3_ovf_once", 32'(bus.overflow), 32'd0);
    auto_busy = 1'b1;
    wait_idle("t3_idle");
    check("t3_n_sent", 32'(emitted.size() - base), 32'd16);
    for (int i = 0; i < 16; i++)
      if (base + i < emitted.size()) check("t3_order", 32'(emitted[base+i]), 32'(i));

    // Push on the same edge as a pop at count 3
    base       = emitted.size();
    auto_busy  = 1'b0;
    force_busy = 1'b1;
    @(negedge clk);
    write_byte(8'hB1);
    write_byte(8'hB2);
    write_byte(8'hB3);
    check("t4_count3", 32'(bus.count), 32'd3);
    force_busy   = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hB4;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check("t4_count_hold", 32'(bus.count),    32'd3);
    check("t4_start",      32'(bus.tx_start), 32'd1);
    check("t4_data",       32'(bus.tx_data),  32'hB1);
    auto_busy = 1'b1;
    wait_idle("t4_idle");
    check("t4_n_sent", 32'(emitted.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < emitted.size()) check("t4_order", 32'(emitted[base+i]), 32'(t4_exp[i]));

    // 20 bytes with uneven gaps so pointers wrap while draining
    base = emitted.size();
    for (int i = 0; i < 20; i++) begin
      write_byte(8'h60 + 8'(i));
      repeat ((i % 4) * 5) @(negedge clk);
    end
    wait_idle("t5_idle");
    check("t5_n_sent", 32'(emitted.size() - base), 32'd20);
    for (int i = 0; i < 20; i++)
      if (base + i < emitted.size()) check("t5_order", 32'(emitted[base+i]), 32'h60 + 32'(i));

    // Flush during SEND with 4 queued; same-cycle write is discarded silently
    base       = emitted.size();
    auto_busy  = 1'b0;
    force_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i));
    force_busy = 1'b0;
    @(negedge clk);
    check("t6_start", 32'(bus.tx_start), 32'd1);
    check("t6_data",  32'(bus.tx_data),  32'hC0);
    check("t6_count", 32'(bus.count),    32'd4);
    force_busy = 1'b1;
    @(negedge clk);
    check("t6_send",  32'(bus.tx_start), 32'd0);
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    check("t6_flush_count", 32'(bus.count),    32'd0);
    check("t6_flush_empty", 32'(bus.empty),    32'd1);
    check("t6_flush_ovf",   32'(bus.overflow), 32'd0);
    force_busy = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_no_relaunch", 32'(emitted.size() - base), 32'd1);
    check("t6_count_end",   32'(bus.count), 32'd0);

    // Reset asserted mid-START drops tx_start without a clock edge
    force_busy = 1'b1;
    write_byte(8'h5A);
    force_busy = 1'b0;
    @(negedge clk);
    check("t7_in_start", 32'(bus.tx_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_start", 32'(bus.tx_start), 32'd0);
    check("t7_async_data",  32'(bus.tx_data),  32'h00);
    check("t7_async_empty", 32'(bus.empty),    32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_after_count", 32'(bus.count),    32'd0);
    check("t7_after_start", 32'(bus.tx_start), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
